// File: rtl/branch_pkg.sv
// Shared types and decode helpers for the branch sequencing controller.
// Holds the FSM state encoding, B-type funct3 codes and the taken-rule.
package branch_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_EVAL     = 2'd1,
      S_REDIRECT = 2'd2,
      S_FLUSH    = 2'd3
   } state_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // 010/011 are reserved encodings in the B-type space.
   function automatic logic f3_reserved(input logic [2:0] f3);
      return (f3 == 3'b010) || (f3 == 3'b011);
   endfunction

   function automatic logic branch_taken(input logic [2:0] f3,
                                         input logic       is_jump,
                                         input logic       lt,
                                         input logic       eq);
      logic t;
      t = 1'b0;
      if (is_jump) begin
         t = 1'b1;
      end else begin
         case (f3)
            F3_BEQ:  t = eq;
            F3_BNE:  t = !eq;
            F3_BLT:  t = lt;
            F3_BGE:  t = !lt;
            F3_BLTU: t = lt;
            F3_BGEU: t = !lt;
            default: t = 1'b0;
         endcase
      end
      return t;
   endfunction

endpackage

// File: rtl/branch_ctrl_sat_counter.sv
// Saturating up-counter used for the branch statistics; holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump sequencing controller: evaluates comparator flags, issues the
// PC redirect, holds the flush window and keeps saturating statistics.
module branch_ctrl
   import branch_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [2:0]       br_funct3,
   input  logic             br_is_jump,
   input  logic [31:0]      br_target,
   output logic             BrUn,
   input  logic             BrLT,
   input  logic             BrEq,
   output logic             stall,
   output logic             pc_sel,
   output logic [31:0]      pc_target,
   input  logic             fetch_ack,
   output logic             flush,
   output logic             illegal,
   output logic             misalign,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);
   localparam bit         NO_FLUSH   = (FLUSH_CYCLES == 0);

   state_e      state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        is_jump_q, is_jump_d;
   logic [31:0] target_q, target_d;
   logic [2:0]  flush_cnt_q, flush_cnt_d;
   logic        illegal_q, illegal_d;
   logic        misalign_q, misalign_d;
   logic        br_inc;
   logic        taken_inc;
   logic        taken_w;

   assign taken_w = branch_taken(funct3_q, is_jump_q, BrLT, BrEq);

   always_comb begin
      state_d     = state_q;
      funct3_d    = funct3_q;
      is_jump_d   = is_jump_q;
      target_d    = target_q;
      flush_cnt_d = flush_cnt_q;
      illegal_d   = 1'b0;
      misalign_d  = 1'b0;
      br_inc      = 1'b0;
      taken_inc   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (br_valid) begin
               funct3_d  = br_funct3;
               is_jump_d = br_is_jump;
               target_d  = br_target;
               br_inc    = 1'b1;
               state_d   = S_EVAL;
            end
         end
         S_EVAL: begin
            illegal_d = !is_jump_q && f3_reserved(funct3_q);
            state_d   = S_IDLE;
            // A misaligned taken target is reported but never redirected.
            if (taken_w) begin
               if (target_q[1:0] != 2'b00) begin
                  misalign_d = 1'b1;
               end else begin
                  taken_inc = 1'b1;
                  state_d   = S_REDIRECT;
               end
            end
         end
         S_REDIRECT: begin
            if (fetch_ack) begin
               if (NO_FLUSH) begin
                  state_d = S_IDLE;
               end else begin
                  flush_cnt_d = FLUSH_INIT;
                  state_d     = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (flush_cnt_q <= 3'd1) begin
               state_d = S_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         flush_cnt_q <= 3'd0;
         illegal_q   <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         illegal_q   <= illegal_d;
         misalign_q  <= misalign_d;
      end
   end

   // Latched instruction fields are only observed outside IDLE, so no reset.
   always_ff @(posedge clk) begin
      funct3_q  <= funct3_d;
      is_jump_q <= is_jump_d;
      target_q  <= target_d;
   end

   assign br_ready  = (state_q == S_IDLE);
   assign stall     = (state_q != S_IDLE);
   assign BrUn      = (state_q == S_EVAL) && !is_jump_q && funct3_q[1];
   assign pc_sel    = (state_q == S_REDIRECT);
   assign pc_target = pc_sel ? target_q : 32'd0;
   assign flush     = (state_q == S_REDIRECT) || (state_q == S_FLUSH);
   assign illegal   = illegal_q;
   assign misalign  = misalign_q;

   sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
      .clk (clk),
      .rst (rst),
      .inc (br_inc),
      .q   (br_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
      .clk (clk),
      .rst (rst),
      .inc (taken_inc),
      .q   (taken_count)
   );

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized transaction-level bench for branch_ctrl; the bench also plays
// the external comparator, evaluating operands under the DUT's BrUn.
module tb_branch_ctrl;

   localparam int FC    = 2;
   localparam int CNT_W = 5;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             br_valid;
   logic             br_ready;
   logic [2:0]       br_funct3;
   logic             br_is_jump;
   logic [31:0]      br_target;
   logic             br_un;
   logic             br_lt;
   logic             br_eq;
   logic             stall;
   logic             pc_sel;
   logic [31:0]      pc_target;
   logic             fetch_ack;
   logic             flush;
   logic             illegal;
   logic             misalign;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] taken_count;

   logic [31:0] op_a;
   logic [31:0] op_b;
   int n_chk  = 0;
   int n_fail = 0;
   int exp_br = 0;
   int exp_tk = 0;

   always #5 clk = ~clk;

   assign br_eq = (op_a == op_b);
   assign br_lt = br_un ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));

   branch_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .br_valid    (br_valid),
      .br_ready    (br_ready),
      .br_funct3   (br_funct3),
      .br_is_jump  (br_is_jump),
      .br_target   (br_target),
      .BrUn        (br_un),
      .BrLT        (br_lt),
      .BrEq        (br_eq),
      .stall       (stall),
      .pc_sel      (pc_sel),
      .pc_target   (pc_target),
      .fetch_ack   (fetch_ack),
      .flush       (flush),
      .illegal     (illegal),
      .misalign    (misalign),
      .br_count    (br_count),
      .taken_count (taken_count)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   // Architectural meaning of each B-type instruction on its operands.
   function automatic bit ref_taken(input logic [2:0] f3, input bit jmp,
                                    input logic [31:0] a, input logic [31:0] b);
      if (jmp) return 1'b1;
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return !($signed(a) < $signed(b));
         3'd6: return a < b;
         3'd7: return !(a < b);
         default: return 1'b0;
      endcase
   endfunction

   task automatic junk_inputs();
      br_valid   = 1'($urandom_range(0, 1));
      br_funct3  = 3'($urandom);
      br_is_jump = 1'($urandom_range(0, 1));
      br_target  = $urandom;
   endtask

   task automatic do_branch(input logic [2:0] f3, input bit jmp, input logic [31:0] tgt,
                            input logic [31:0] a, input logic [31:0] b,
                            input int ack_dly, input bit rst_mid);
      bit ill_e, tk_e, mis_e, redir;
      ill_e = !jmp && (f3 == 3'd2 || f3 == 3'd3);
      tk_e  = ref_taken(f3, jmp, a, b);
      mis_e = tk_e && (tgt[1:0] != 2'b00);
      redir = tk_e && !mis_e;

      chk("idle_ready", br_ready, 1);
      chk("idle_stall", stall, 0);
      br_valid = 1'b1; br_funct3 = f3; br_is_jump = jmp; br_target = tgt;
      @(negedge clk);
      exp_br = sat(exp_br + 1);
      junk_inputs();
      op_a = a; op_b = b;
      chk("eval_stall", stall, 1);
      chk("eval_ready", br_ready, 0);
      chk("eval_brun", br_un, jmp ? 1'b0 : f3[1]);
      chk("br_count", br_count, exp_br);
      chk("eval_pc_sel", pc_sel, 0);
      @(negedge clk);
      br_valid = 1'b0;
      chk("illegal", illegal, ill_e);
      chk("misalign", misalign, mis_e);
      chk("pc_sel_c2", pc_sel, redir);
      if (redir) exp_tk = sat(exp_tk + 1);
      chk("taken_count", taken_count, exp_tk);
      if (!redir) begin
         chk("nt_ready_c2", br_ready, 1);
         return;
      end
      if (rst_mid) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         exp_br = 0; exp_tk = 0;
         chk("rst_pc_sel", pc_sel, 0);
         chk("rst_flush", flush, 0);
         chk("rst_ready", br_ready, 1);
         chk("rst_stall", stall, 0);
         chk("rst_pc_target", pc_target, 0);
         chk("rst_br_count", br_count, 0);
         chk("rst_taken_count", taken_count, 0);
         return;
      end
      for (int i = 0; i <= ack_dly; i++) begin
         chk("redir_pc_sel", pc_sel, 1);
         chk("redir_target", pc_target, tgt);
         chk("redir_flush", flush, 1);
         chk("redir_stall", stall, 1);
         fetch_ack = (i == ack_dly);
         junk_inputs();
         @(negedge clk);
      end
      fetch_ack = 1'b0;
      for (int i = 0; i < FC; i++) begin
         chk("fl_flush", flush, 1);
         chk("fl_pc_sel", pc_sel, 0);
         chk("fl_ready", br_ready, 0);
         junk_inputs();
         @(negedge clk);
      end
      br_valid = 1'b0;
      chk("post_ready", br_ready, 1);
      chk("post_flush", flush, 0);
      chk("post_taken_count", taken_count, exp_tk);
   endtask

   task automatic idle_gap();
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
         fetch_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("gap_pc_sel", pc_sel, 0);
         chk("gap_ready", br_ready, 1);
      end
      fetch_ack = 1'b0;
   endtask

   function automatic logic [31:0] rnd_op();
      logic [31:0] v;
      v = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) v = ~v;
      return v;
   endfunction

   task automatic rand_branch();
      logic [31:0] tgt;
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      do_branch(3'($urandom), ($urandom_range(0, 5) == 0), tgt, rnd_op(), rnd_op(),
                $urandom_range(0, 3), 1'b0);
      idle_gap();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; br_valid = 1'b0; br_funct3 = 3'd0; br_is_jump = 1'b0;
      br_target = 32'd0; fetch_ack = 1'b0; op_a = 32'd0; op_b = 32'd0;
      repeat (2) @(negedge clk);
      chk("reset_ready", br_ready, 1);
      chk("reset_stall", stall, 0);
      chk("reset_pc_sel", pc_sel, 0);
      chk("reset_flush", flush, 0);
      chk("reset_illegal", illegal, 0);
      chk("reset_misalign", misalign, 0);
      chk("reset_brun", br_un, 0);
      chk("reset_pc_target", pc_target, 0);
      chk("reset_br_count", br_count, 0);
      chk("reset_taken_count", taken_count, 0);
      rst = 1'b0;
      @(negedge clk);

      do_branch(3'b000, 1'b0, 32'h0000_0100, 32'd7, 32'd7, 0, 1'b0);
      do_branch(3'b110, 1'b0, 32'h0000_0040, 32'd5, 32'hFFFF_FFFF, 0, 1'b0);
      do_branch(3'b101, 1'b0, 32'h0000_0102, 32'd5, 32'd2, 0, 1'b0);
      do_branch(3'b011, 1'b0, 32'h0000_0080, 32'd1, 32'd2, 0, 1'b0);
      do_branch(3'b000, 1'b1, 32'h0000_0200, 32'd1, 32'd2, 3, 1'b0);
      for (int k = 0; k < 80; k++) rand_branch();
      do_branch(3'b000, 1'b1, 32'h0000_0300, 32'd0, 32'd0, 0, 1'b1);
      for (int k = 0; k < 40; k++) rand_branch();
      chk("final_br_count", br_count, exp_br);
      chk("final_taken_count", taken_count, exp_tk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
